// File: rtl/_pipe_reg_pkg.sv
// rtl/_pipe_reg_pkg.sv - shared constants and elaboration helper for the pipeline register
package _pipe_reg_pkg;

    // Default data width of a pipeline word.
    localparam int BIT_WIDTH = 8;

    // Default number of register stages.
    localparam int DEFAULT_DEPTH = 2;

    // A pipeline needs at least one stage and at least one data bit.
    function automatic bit cfg_ok(input int width, input int depth);
        return (width >= 1) && (depth >= 1);
    endfunction

endpackage

// File: rtl/_pipe_reg_if.sv
// rtl/_pipe_reg_if.sv - upstream/downstream valid-ready handshake bundle
interface _pipe_reg_if
    import _pipe_reg_pkg::*;
#(
    parameter int n = BIT_WIDTH
) ();

    logic         in_valid;
    logic         in_ready;
    logic [n-1:0] D;
    logic         out_valid;
    logic         out_ready;
    logic [n-1:0] Q;

    // Pipeline side: consumes the upstream word, produces the downstream word.
    modport slave (
        input  in_valid,
        input  D,
        input  out_ready,
        output in_ready,
        output out_valid,
        output Q
    );

    // Environment side: drives upstream data and downstream back-pressure.
    modport master (
        output in_valid,
        output D,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  Q
    );

endinterface

// File: rtl/_pipe_stage.sv
// rtl/_pipe_stage.sv - single valid/data pipeline slot with load, flush and async reset
module _pipe_stage
    import _pipe_reg_pkg::*;
#(
    parameter int           n       = BIT_WIDTH,
    parameter logic [n-1:0] RST_VAL = {n{1'b0}}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_load,
    input  logic         i_valid,
    input  logic [n-1:0] i_data,
    output logic         o_valid,
    output logic [n-1:0] o_data
);

    logic         r_valid;
    logic [n-1:0] r_data;

    // Clear on reset/flush; when loading, take the incoming valid and keep old data behind a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= RST_VAL;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_data  <= RST_VAL;
        end else if (i_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/_pipe_reg.sv
// rtl/_pipe_reg.sv - DEPTH-stage valid/ready pipeline register with bubble collapse and flush
module _pipe_reg
    import _pipe_reg_pkg::*;
#(
    parameter int           n       = BIT_WIDTH,
    parameter int           DEPTH   = DEFAULT_DEPTH,
    parameter logic [n-1:0] RST_VAL = {n{1'b0}}
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    _pipe_reg_if.slave  bus
);

    if (!cfg_ok(n, DEPTH)) begin : g_cfg_err
        $error("_pipe_reg: n and DEPTH must both be at least 1");
    end

    logic [DEPTH:0]   w_ready;
    logic [DEPTH-1:0] w_valid;
    logic [n-1:0]     w_data     [DEPTH];
    logic [DEPTH-1:0] w_src_valid;
    logic [n-1:0]     w_src_data [DEPTH];

    // Ready ripples back from the sink: a stage may load if it is empty or its successor can load.
    // Flush is deliberately kept out of this path.
    always_comb begin
        w_ready        = '0;
        w_ready[DEPTH] = bus.out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_ready[i] = ~w_valid[i] | w_ready[i + 1];
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_src_in
            assign w_src_valid[i] = bus.in_valid;
            assign w_src_data[i]  = bus.D;
        end else begin : g_src_prev
            assign w_src_valid[i] = w_valid[i - 1];
            assign w_src_data[i]  = w_data[i - 1];
        end

        _pipe_stage #(
            .n       (n),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_flush (flush),
            .i_load  (w_ready[i]),
            .i_valid (w_src_valid[i]),
            .i_data  (w_src_data[i]),
            .o_valid (w_valid[i]),
            .o_data  (w_data[i])
        );
    end

    // Outputs come straight from the last stage's registers.
    assign bus.in_ready  = w_ready[0];
    assign bus.out_valid = w_valid[DEPTH - 1];
    assign bus.Q         = w_data[DEPTH - 1];

endmodule

// File: tb/tb__pipe_reg.sv
// tb/tb__pipe_reg.sv - scoreboard bench for _pipe_reg at DEPTH 3, 1, 2 and 4
module tb__pipe_reg;

    localparam int          NI          = 4;
    localparam int          DEPTHS [NI] = '{3, 1, 2, 4};
    localparam logic [7:0]  RV0         = 8'hE5;
    localparam int          MAXC        = 512;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NI-1:0] flush_a;
    logic [NI-1:0] in_valid_a;
    logic [NI-1:0] out_ready_a;
    logic [7:0]    d_a [NI];
    logic [NI-1:0] in_ready_a;
    logic [NI-1:0] out_valid_a;
    logic [7:0]    q_a [NI];
    logic          final_chk;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int         DP = DEPTHS[g];
        localparam logic [7:0] RV = (g == 0) ? RV0 : 8'h3C;

        _pipe_reg_if #(.n(8)) bus ();

        assign bus.in_valid   = in_valid_a[g];
        assign bus.D          = d_a[g];
        assign bus.out_ready  = out_ready_a[g];
        assign in_ready_a[g]  = bus.in_ready;
        assign out_valid_a[g] = bus.out_valid;
        assign q_a[g]         = bus.Q;

        _pipe_reg #(.n(8), .DEPTH(DP), .RST_VAL(RV)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (flush_a[g]),
            .bus   (bus)
        );
    end

    // Timed expectations for instance 0: slot 0 out_valid, 1 Q, 2 in_ready.
    bit         exp_en  [MAXC][3];
    logic [7:0] exp_val [MAXC][3];
    string      exp_tag [MAXC][3];

    int         cyc      = 0;
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] sbq [NI][$];

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d cyc=%0d actual=%0h expected=%0h", nm, k, cyc, act, exp);
        end
    endtask

    // Monitor: timed directed checks plus a per-instance FIFO scoreboard.
    initial begin : monitor
        logic [7:0] act;
        forever begin
            @(negedge clk);
            if (cyc < MAXC) begin
                for (int s = 0; s < 3; s++) begin
                    if (exp_en[cyc][s]) begin
                        case (s)
                            0:       act = {7'b0, out_valid_a[0]};
                            1:       act = q_a[0];
                            default: act = {7'b0, in_ready_a[0]};
                        endcase
                        chk(exp_tag[cyc][s], 0, {24'b0, act}, {24'b0, exp_val[cyc][s]});
                    end
                end
            end
            if (!rst_n) begin
                for (int k = 0; k < NI; k++) sbq[k].delete();
            end else begin
                for (int k = 0; k < NI; k++) begin
                    chk("in_ready_rule", k, {31'b0, in_ready_a[k]},
                        {31'b0, (sbq[k].size() < DEPTHS[k]) || out_ready_a[k]});
                    if (flush_a[k]) begin
                        sbq[k].delete();
                    end else begin
                        if (out_valid_a[k] && out_ready_a[k]) begin
                            if (sbq[k].size() == 0) begin
                                checks++;
                                failures++;
                                $display("FAIL spurious_out inst=%0d cyc=%0d actual=%0h expected=none", k, cyc, q_a[k]);
                            end else begin
                                chk("order_q", k, {24'b0, q_a[k]}, {24'b0, sbq[k].pop_front()});
                            end
                        end
                        if (in_valid_a[k] && in_ready_a[k]) sbq[k].push_back(d_a[k]);
                    end
                end
            end
            if (final_chk) begin
                for (int k = 0; k < NI; k++) begin
                    chk("drain_empty", k, sbq[k].size(), 0);
                    chk("drain_ov", k, {31'b0, out_valid_a[k]}, 0);
                end
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int c, input int s, input logic [7:0] v, input string nm);
        exp_en[c][s]  = 1'b1;
        exp_val[c][s] = v;
        exp_tag[c][s] = nm;
    endtask

    task automatic idle_all();
        in_valid_a  = '0;
        out_ready_a = '1;
        flush_a     = '0;
        for (int k = 0; k < NI; k++) d_a[k] = 8'h00;
    endtask

    initial begin : stim
        int L;
        rst_n     = 1'b1;
        final_chk = 1'b0;
        idle_all();
        #2 rst_n = 1'b0;
        expect_at(1, 0, 8'h00, "rst_ov");
        expect_at(1, 1, RV0,   "rst_q");
        expect_at(1, 2, 8'h01, "rst_rdy");
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Streaming latency and throughput
        L = cyc;
        expect_at(L + 2, 0, 8'h00, "A_not_early");
        for (int i = 0; i < 5; i++) begin
            in_valid_a[0] = 1'b1;
            d_a[0] = 8'(i + 1);
            expect_at(L + 3 + i, 0, 8'h01, "A_ov");
            expect_at(L + 3 + i, 1, 8'(i + 1), "A_q");
            tick();
        end
        in_valid_a[0] = 1'b0;
        expect_at(L + 8, 0, 8'h00, "A_done");
        repeat (6) tick();

        // Fill with back-pressure, then release
        L = cyc;
        in_valid_a[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d_a[0] = (i < 4) ? 8'(8'hA1 + i) : 8'hA4;
            out_ready_a[0] = (i == 5);
            tick();
        end
        in_valid_a[0] = 1'b0;
        out_ready_a[0] = 1'b1;
        expect_at(L,     2, 8'h01, "B_rdy0");
        expect_at(L + 1, 2, 8'h01, "B_rdy1");
        expect_at(L + 2, 2, 8'h01, "B_rdy2");
        expect_at(L + 3, 2, 8'h00, "B_full");
        expect_at(L + 4, 2, 8'h00, "B_full_hold");
        expect_at(L + 5, 2, 8'h01, "B_rdy_release");
        expect_at(L + 3, 1, 8'hA1, "B_q_hold0");
        expect_at(L + 4, 1, 8'hA1, "B_q_hold1");
        for (int i = 0; i < 4; i++) begin
            expect_at(L + 5 + i, 0, 8'h01, "B_ov");
            expect_at(L + 5 + i, 1, 8'(8'hA1 + i), "B_q");
        end
        expect_at(L + 9, 0, 8'h00, "B_done");
        repeat (6) tick();

        // Full pipeline accepts and delivers in the same cycle
        L = cyc;
        out_ready_a[0] = 1'b0;
        in_valid_a[0]  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d_a[0] = 8'(8'hB1 + i);
            tick();
        end
        out_ready_a[0] = 1'b1;
        d_a[0] = 8'h55;
        expect_at(L + 3, 2, 8'h01, "C_rdy_full");
        expect_at(L + 3, 1, 8'hB1, "C_q0");
        expect_at(L + 4, 1, 8'hB2, "C_q1");
        expect_at(L + 5, 1, 8'hB3, "C_q2");
        expect_at(L + 6, 1, 8'h55, "C_q55");
        expect_at(L + 6, 0, 8'h01, "C_ov55");
        expect_at(L + 7, 0, 8'h00, "C_done");
        tick();
        in_valid_a[0] = 1'b0;
        repeat (6) tick();

        // Flush with two words in flight and a word offered
        L = cyc;
        out_ready_a[0] = 1'b0;
        in_valid_a[0]  = 1'b1;
        d_a[0] = 8'hC1; tick();
        d_a[0] = 8'hC2; tick();
        flush_a[0] = 1'b1;
        d_a[0] = 8'h77;
        tick();
        idle_all();
        expect_at(L + 3, 0, 8'h00, "D_ov");
        expect_at(L + 3, 1, RV0,   "D_q");
        expect_at(L + 3, 2, 8'h01, "D_rdy");
        expect_at(L + 4, 0, 8'h00, "D_no77_a");
        expect_at(L + 5, 0, 8'h00, "D_no77_b");
        expect_at(L + 6, 0, 8'h00, "D_no77_c");
        repeat (6) tick();

        // Flush on a full pipeline does not raise in_ready
        L = cyc;
        out_ready_a[0] = 1'b0;
        in_valid_a[0]  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d_a[0] = 8'(8'hE1 + i);
            tick();
        end
        flush_a[0] = 1'b1;
        d_a[0] = 8'h99;
        expect_at(L + 3, 2, 8'h00, "E_rdy_flush");
        expect_at(L + 3, 1, 8'hE1, "E_q_full");
        expect_at(L + 4, 0, 8'h00, "E_ov");
        expect_at(L + 4, 1, RV0,   "E_q");
        tick();
        idle_all();
        repeat (5) tick();

        // Asynchronous reset while full
        L = cyc;
        out_ready_a[0] = 1'b0;
        in_valid_a[0]  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d_a[0] = 8'(8'hF1 + i);
            tick();
        end
        in_valid_a[0] = 1'b0;
        #2 rst_n = 1'b0;
        expect_at(L + 3, 0, 8'h00, "F_rst_ov");
        expect_at(L + 3, 1, RV0,   "F_rst_q");
        tick();
        rst_n = 1'b1;
        out_ready_a[0] = 1'b1;
        expect_at(L + 4, 2, 8'h01, "F_rdy");
        tick();
        in_valid_a[0] = 1'b1;
        d_a[0] = 8'h10;
        expect_at(L + 5, 2, 8'h01, "F_rdy_push");
        expect_at(L + 7, 0, 8'h00, "F_not_early");
        expect_at(L + 8, 0, 8'h01, "F_ov");
        expect_at(L + 8, 1, 8'h10, "F_q");
        tick();
        in_valid_a[0] = 1'b0;
        repeat (6) tick();

        // Random traffic on every depth
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < NI; k++) begin
                in_valid_a[k]  = ($urandom_range(0, 99) < 65);
                out_ready_a[k] = ($urandom_range(0, 99) < ((c < 5000) ? 50 : 85));
                flush_a[k]     = ($urandom_range(0, 399) == 0);
                d_a[k]         = 8'($urandom_range(0, 255));
            end
            tick();
        end

        idle_all();
        repeat (10) tick();
        final_chk = 1'b1;
        tick();
        final_chk = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
